// File: rtl/serial_endpoint.sv
// Device-side partner of the processor serial port: a host->CPU RX byte FIFO and a
// CPU->host TX byte FIFO, each show-ahead with registered occupancy and flags.

module serial_endpoint_fifo #(
    parameter int ADDR_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push_in,
    input  logic [7:0]        push_data_in,
    input  logic              pop_in,
    output logic [7:0]        data_out,
    output logic              valid_out,
    output logic              ready_out,
    output logic [ADDR_W:0]   count_out
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_C = {1'b1, {ADDR_W{1'b0}}};

    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        mem_d [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_d;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic              push_s;
    logic              pop_s;

    // Flags come only from the registered count, so no input reaches an output.
    assign valid_out = (count_q != {(ADDR_W+1){1'b0}});
    assign ready_out = (count_q != FULL_C);
    assign count_out = count_q;
    assign data_out  = mem_q[rd_ptr_q];

    // Qualified transfers, next pointers, occupancy and storage contents.
    always_comb begin
        push_s   = push_in && ready_out;
        pop_s    = pop_in && valid_out;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = push_data_in;
            wr_ptr_d        = wr_ptr_q + ADDR_W'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1'b1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // State register; storage is cleared too so the data output reads 0x00 after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q    <= '{default: 8'h00};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

module serial_endpoint #(
    parameter int ADDR_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    output logic [7:0]        cpu_data_out,
    output logic              cpu_valid_out,
    output logic              cpu_ready_out,
    input  logic [7:0]        cpu_data_in,
    input  logic              cpu_rden_in,
    input  logic              cpu_wren_in,
    input  logic [7:0]        host_rx_data_in,
    input  logic              host_rx_valid_in,
    output logic              host_rx_ready_out,
    output logic [7:0]        host_tx_data_out,
    output logic              host_tx_valid_out,
    input  logic              host_tx_ready_in,
    output logic [ADDR_W:0]   rx_count_out,
    output logic [ADDR_W:0]   tx_count_out,
    output logic              rx_underflow_out,
    output logic              tx_overflow_out
);
    logic rx_underflow_q;
    logic rx_underflow_d;
    logic tx_overflow_q;
    logic tx_overflow_d;

    serial_endpoint_fifo #(.ADDR_W(ADDR_W)) u_rx_fifo (
        .clock        (clock),
        .reset        (reset),
        .push_in      (host_rx_valid_in),
        .push_data_in (host_rx_data_in),
        .pop_in       (cpu_rden_in),
        .data_out     (cpu_data_out),
        .valid_out    (cpu_valid_out),
        .ready_out    (host_rx_ready_out),
        .count_out    (rx_count_out)
    );

    serial_endpoint_fifo #(.ADDR_W(ADDR_W)) u_tx_fifo (
        .clock        (clock),
        .reset        (reset),
        .push_in      (cpu_wren_in),
        .push_data_in (cpu_data_in),
        .pop_in       (host_tx_ready_in),
        .data_out     (host_tx_data_out),
        .valid_out    (host_tx_valid_out),
        .ready_out    (cpu_ready_out),
        .count_out    (tx_count_out)
    );

    assign rx_underflow_out = rx_underflow_q;
    assign tx_overflow_out  = tx_overflow_q;

    // Sticky error detection: read of an empty RX, write into a full TX.
    always_comb begin
        rx_underflow_d = rx_underflow_q;
        tx_overflow_d  = tx_overflow_q;
        if (cpu_rden_in && !cpu_valid_out) begin
            rx_underflow_d = 1'b1;
        end else begin
            rx_underflow_d = rx_underflow_q;
        end
        if (cpu_wren_in && !cpu_ready_out) begin
            tx_overflow_d = 1'b1;
        end else begin
            tx_overflow_d = tx_overflow_q;
        end
    end

    // Sticky flag registers, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_underflow_q <= 1'b0;
            tx_overflow_q  <= 1'b0;
        end else begin
            rx_underflow_q <= rx_underflow_d;
            tx_overflow_q  <= tx_overflow_d;
        end
    end
endmodule
